// File: rtl/syscall_pkg.sv
// syscall_pkg: opcodes and FSM state encoding shared by the SYSCALL I/O controller.
package syscall_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [5:0] OP_SYS_IN  = 6'b110011;
  localparam logic [5:0] OP_SYS_OUT = 6'b110111;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 2'd0,
    ARM        = 2'd1,
    WAIT_PRESS = 2'd2,
    COMMIT     = 2'd3
  } state_e;

endpackage

// File: rtl/syscall_io_controller_debouncer.sv
// button_debouncer: two-flop synchronizer followed by a counter that only lets
// the debounced level follow the input after DEBOUNCE_CYCLES disagreeing samples.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_async_i,
  output logic btn_level_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Bring the asynchronous pushbutton into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_async_i};
    end
  end

  // Count consecutive disagreeing samples; flip the level when the run is long enough.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        cnt_d   = {CNT_W{1'b0}};
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level_o = level_q;

endmodule

// File: rtl/syscall_io_controller.sv
// syscall_io_controller: stalls the CPU on SYSCALL input until the user confirms
// the switch value with a fresh button press, then commits it for one cycle;
// latches the printed register value on SYSCALL output.
// Optional feature macro: SYSCALL_OUT_ACK_EN (SYS_OUT also waits for a release+press).
module syscall_io_controller
  import syscall_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned SW_WIDTH        = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            opcode,
  input  logic [DATA_WIDTH-1:0] reg_value,
  input  logic [SW_WIDTH-1:0]   sw_in,
  input  logic                  btn_confirm,
  output logic                  cpu_run,
  output logic                  in_sel,
  output logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] disp_value,
  output logic                  disp_valid,
  output logic                  waiting
);

  state_e                state_q;
  state_e                state_d;
  logic [DATA_WIDTH-1:0] in_data_q;
  logic [DATA_WIDTH-1:0] in_data_d;
  logic [DATA_WIDTH-1:0] disp_value_q;
  logic [DATA_WIDTH-1:0] disp_value_d;
  logic                  disp_valid_q;
  logic                  disp_valid_d;
  logic                  in_sel_q;
  logic                  in_sel_d;
  logic                  waiting_q;
  logic                  waiting_d;
  logic                  ack_q;     // current sequence is a SYS_OUT acknowledge, not an input
  logic                  ack_d;
  logic                  btn_level_s;
  logic                  cpu_run_s;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_async_i(btn_confirm),
    .btn_level_o(btn_level_s)
  );

  // Sequencing FSM: next state, captured data and the combinational stall.
  always_comb begin
    state_d      = state_q;
    in_data_d    = in_data_q;
    disp_value_d = disp_value_q;
    disp_valid_d = disp_valid_q;
    ack_d        = ack_q;
    cpu_run_s    = 1'b1;
    case (state_q)
      IDLE: begin
        if (opcode == OP_SYS_IN) begin
          cpu_run_s = 1'b0;
          ack_d     = 1'b0;
          state_d   = ARM;
        end else if (opcode == OP_SYS_OUT) begin
          disp_value_d = reg_value;
          disp_valid_d = 1'b1;
`ifdef SYSCALL_OUT_ACK_EN
          cpu_run_s = 1'b0;
          ack_d     = 1'b1;
          state_d   = ARM;
`else
          cpu_run_s = 1'b1;
          state_d   = IDLE;
`endif
        end else begin
          cpu_run_s = 1'b1;
          state_d   = IDLE;
        end
      end
      ARM: begin
        // A button still held from before cannot count as confirmation.
        cpu_run_s = 1'b0;
        if (!btn_level_s) begin
          state_d = WAIT_PRESS;
        end else begin
          state_d = ARM;
        end
      end
      WAIT_PRESS: begin
        cpu_run_s = 1'b0;
        if (btn_level_s) begin
          if (!ack_q) begin
            in_data_d = DATA_WIDTH'(sw_in);
          end else begin
            in_data_d = in_data_q;
          end
          state_d = COMMIT;
        end else begin
          state_d = WAIT_PRESS;
        end
      end
      COMMIT: begin
        cpu_run_s = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        cpu_run_s = 1'b1;
        state_d   = IDLE;
      end
    endcase
    waiting_d = (state_d == ARM) || (state_d == WAIT_PRESS);
    in_sel_d  = (state_d == COMMIT) && !ack_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_data_q    <= {DATA_WIDTH{1'b0}};
      disp_value_q <= {DATA_WIDTH{1'b0}};
      disp_valid_q <= 1'b0;
      in_sel_q     <= 1'b0;
      waiting_q    <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_data_q    <= in_data_d;
      disp_value_q <= disp_value_d;
      disp_valid_q <= disp_valid_d;
      in_sel_q     <= in_sel_d;
      waiting_q    <= waiting_d;
      ack_q        <= ack_d;
    end
  end

  assign cpu_run    = cpu_run_s;
  assign in_sel     = in_sel_q;
  assign in_data    = in_data_q;
  assign disp_value = disp_value_q;
  assign disp_valid = disp_valid_q;
  assign waiting    = waiting_q;

endmodule

// File: tb/tb_syscall_io_controller.sv
// tb_syscall_io_controller: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the user-interaction protocol.
`timescale 1ns/1ps
module tb_syscall_io_controller;

  localparam int DW  = 32;
  localparam int SWW = 16;
  localparam int DB  = 4;
  localparam logic [5:0] SYS_IN  = 6'b110011;
  localparam logic [5:0] SYS_OUT = 6'b110111;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [5:0]     opcode = 6'd0;
  logic [DW-1:0]  reg_value = '0;
  logic [SWW-1:0] sw_in = '0;
  logic           btn = 1'b0;
  logic           cpu_run;
  logic           in_sel;
  logic           disp_valid;
  logic           waiting;
  logic [DW-1:0]  in_data;
  logic [DW-1:0]  disp_value;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  syscall_io_controller #(
    .DATA_WIDTH(DW), .SW_WIDTH(SWW), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .reg_value(reg_value),
    .sw_in(sw_in), .btn_confirm(btn), .cpu_run(cpu_run), .in_sel(in_sel),
    .in_data(in_data), .disp_value(disp_value), .disp_valid(disp_valid),
    .waiting(waiting)
  );

  wire [2*DW+3:0] obs = {cpu_run, in_sel, waiting, disp_valid, in_data, disp_value};
  logic [2*DW+3:0] rst_exp;

  // Behavioural model. Phases of the user protocol:
  // 0 = CPU running, 1 = waiting for the button to be released,
  // 2 = waiting for a press, 3 = resume cycle (value written if an input).
  int            m_phase = 0;
  bit            m_ack = 1'b0;
  bit            m_lvl = 1'b0;
  int            m_run = 0;
  bit            m_raw0 = 1'b0;
  bit            m_raw1 = 1'b0;
  logic [DW-1:0] m_in = '0;
  logic [DW-1:0] m_disp = '0;
  bit            m_dv = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_ack <= 1'b0; m_lvl <= 1'b0; m_run <= 0;
      m_raw0 <= 1'b0; m_raw1 <= 1'b0; m_in <= '0; m_disp <= '0; m_dv <= 1'b0;
    end else begin
      // button seen by the debouncer is the raw sample from two edges ago
      m_raw0 <= m_raw1;
      m_raw1 <= btn;
      if (m_raw0 != m_lvl) begin
        if (m_run + 1 >= DB) begin m_lvl <= ~m_lvl; m_run <= 0; end
        else m_run <= m_run + 1;
      end else begin
        m_run <= 0;
      end
      case (m_phase)
        0: begin
          if (opcode == SYS_IN) begin m_phase <= 1; m_ack <= 1'b0; end
          else if (opcode == SYS_OUT) begin
            m_disp <= reg_value; m_dv <= 1'b1;
`ifdef SYSCALL_OUT_ACK_EN
            m_phase <= 1; m_ack <= 1'b1;
`endif
          end
        end
        1: if (!m_lvl) m_phase <= 2;
        2: if (m_lvl) begin
             if (!m_ack) m_in <= {{(DW-SWW){1'b0}}, sw_in};
             m_phase <= 3;
           end
        default: m_phase <= 0;
      endcase
    end
  end

  function logic [2*DW+3:0] exp_vec();
    logic run_e;
    run_e = !(m_phase == 1 || m_phase == 2);
    if (m_phase == 0 && opcode == SYS_IN) run_e = 1'b0;
`ifdef SYSCALL_OUT_ACK_EN
    if (m_phase == 0 && opcode == SYS_OUT) run_e = 1'b0;
`endif
    return {run_e, (m_phase == 3 && !m_ack), (m_phase == 1 || m_phase == 2), m_dv, m_in, m_disp};
  endfunction

  task test_reset;
    rst_exp = {1'b1, 3'b000, {(2*DW){1'b0}}};
    opcode = 6'd0; btn = 1'b0;
    #2 rst_n = 1'b0;
    #1; vectors++;
    if (obs !== rst_exp) begin miscompares++; $display("FAIL reset_values: got %h want %h", obs, rst_exp); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL reset_idle: got %h want %h", obs, exp_vec()); end
    end
  endtask

  task test_sys_in;
    int lat;
    lat = 0;
    opcode = SYS_IN; sw_in = 16'h00A5; btn = 1'b0;
    #1; vectors++;
    if (cpu_run !== 1'b0) begin miscompares++; $display("FAIL sys_in_same_cycle_stall: cpu_run %b want 0", cpu_run); end
    repeat (20) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL sys_in_wait: got %h want %h", obs, exp_vec()); end
    end
    btn = 1'b1;
    for (int i = 1; i <= 15 && lat == 0; i++) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL sys_in_press: got %h want %h", obs, exp_vec()); end
      if (in_sel === 1'b1) lat = i;
    end
    vectors++;
    if (lat != 7) begin miscompares++; $display("FAIL sys_in_latency: got %0d want 7", lat); end
    vectors++;
    if (in_data !== 32'h000000A5) begin miscompares++; $display("FAIL sys_in_data: got %h want 000000a5", in_data); end
    opcode = 6'd0; btn = 1'b0;
    repeat (10) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL sys_in_after: got %h want %h", obs, exp_vec()); end
    end
  endtask

  task test_held_button;
    int seen;
    seen = 0;
    btn = 1'b1; opcode = 6'd0;
    repeat (10) @(negedge clk);
    opcode = SYS_IN; sw_in = 16'h1234;
    repeat (30) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL held_model: got %h want %h", obs, exp_vec()); end
      if (in_sel === 1'b1) begin miscompares++; $display("FAIL held_commit: in_sel %b want 0", in_sel); end
    end
    vectors++;
    if (waiting !== 1'b1 || cpu_run !== 1'b0) begin
      miscompares++; $display("FAIL held_stalled: waiting %b cpu_run %b want 1 0", waiting, cpu_run);
    end
    btn = 1'b0;
    repeat (10) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL held_release: got %h want %h", obs, exp_vec()); end
    end
    btn = 1'b1;
    for (int i = 0; i < 15 && seen == 0; i++) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL held_press: got %h want %h", obs, exp_vec()); end
      if (in_sel === 1'b1) seen = 1;
    end
    vectors++;
    if (seen == 0 || in_data !== 32'h00001234) begin
      miscompares++; $display("FAIL held_fresh_press: seen %0d in_data %h want 1 00001234", seen, in_data);
    end
    opcode = 6'd0; btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task test_glitch;
    opcode = SYS_IN; sw_in = 16'h5A5A; btn = 1'b0;
    repeat (5) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL glitch_arm: got %h want %h", obs, exp_vec()); end
    end
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (20) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL glitch_model: got %h want %h", obs, exp_vec()); end
      if (in_sel === 1'b1) begin miscompares++; $display("FAIL glitch_capture: in_sel %b want 0", in_sel); end
    end
    vectors++;
    if (cpu_run !== 1'b0 || waiting !== 1'b1) begin
      miscompares++; $display("FAIL glitch_still_stalled: cpu_run %b waiting %b want 0 1", cpu_run, waiting);
    end
  endtask

  task test_reset_mid;
    opcode = 6'd0;
    #2 rst_n = 1'b0;
    #1; vectors++;
    if (obs !== rst_exp) begin miscompares++; $display("FAIL reset_mid_async: got %h want %h", obs, rst_exp); end
    @(negedge clk);
    rst_n = 1'b1; btn = 1'b1;
    repeat (15) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL reset_mid_model: got %h want %h", obs, exp_vec()); end
      if (in_sel === 1'b1) begin miscompares++; $display("FAIL reset_mid_commit: in_sel %b want 0", in_sel); end
    end
    vectors++;
    if (cpu_run !== 1'b1 || waiting !== 1'b0 || in_data !== 32'h0) begin
      miscompares++; $display("FAIL reset_mid_idle: cpu_run %b waiting %b in_data %h want 1 0 0", cpu_run, waiting, in_data);
    end
    btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task test_sys_out;
    logic [DW-1:0] saved;
    int done;
    saved = in_data; done = 0;
    opcode = SYS_OUT; reg_value = 32'hDEADBEEF;
    #1; vectors++;
`ifdef SYSCALL_OUT_ACK_EN
    if (cpu_run !== 1'b0) begin miscompares++; $display("FAIL sys_out_stall: cpu_run %b want 0", cpu_run); end
`else
    if (cpu_run !== 1'b1) begin miscompares++; $display("FAIL sys_out_no_stall: cpu_run %b want 1", cpu_run); end
`endif
    @(negedge clk); vectors++;
    if (obs !== exp_vec()) begin miscompares++; $display("FAIL sys_out_model: got %h want %h", obs, exp_vec()); end
    opcode = 6'd0; reg_value = 32'h12345678;
    vectors++;
    if (disp_value !== 32'hDEADBEEF || disp_valid !== 1'b1) begin
      miscompares++; $display("FAIL sys_out_latch: disp %h valid %b want deadbeef 1", disp_value, disp_valid);
    end
`ifdef SYSCALL_OUT_ACK_EN
    vectors++;
    if (waiting !== 1'b1) begin miscompares++; $display("FAIL sys_out_ack_wait: waiting %b want 1", waiting); end
    btn = 1'b1;
    for (int i = 0; i < 20 && done == 0; i++) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL sys_out_ack_model: got %h want %h", obs, exp_vec()); end
      if (in_sel === 1'b1) begin miscompares++; $display("FAIL sys_out_ack_in_sel: in_sel %b want 0", in_sel); end
      if (cpu_run === 1'b1) done = 1;
    end
    vectors++;
    if (done == 0 || in_data !== saved) begin
      miscompares++; $display("FAIL sys_out_ack_resume: done %0d in_data %h want 1 %h", done, in_data, saved);
    end
    btn = 1'b0;
`else
    repeat (5) begin
      @(negedge clk); vectors++;
      if (cpu_run !== 1'b1 || obs !== exp_vec()) begin
        miscompares++; $display("FAIL sys_out_run: got %h want %h", obs, exp_vec());
      end
    end
`endif
    repeat (10) @(negedge clk);
    vectors++;
    if (disp_value !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sys_out_persist: disp %h want deadbeef", disp_value); end
  endtask

  task test_back_to_back;
    logic [SWW-1:0] vals [2];
    int seen;
    vals[0] = 16'h0001; vals[1] = 16'hFFFF;
    opcode = SYS_IN;
    for (int k = 0; k < 2; k++) begin
      sw_in = vals[k];
      repeat (8) begin
        @(negedge clk); vectors++;
        if (obs !== exp_vec()) begin miscompares++; $display("FAIL b2b_arm: got %h want %h", obs, exp_vec()); end
      end
      btn = 1'b0;
      repeat (8) @(negedge clk);
      btn = 1'b1; seen = 0;
      for (int i = 0; i < 15 && seen == 0; i++) begin
        @(negedge clk); vectors++;
        if (obs !== exp_vec()) begin miscompares++; $display("FAIL b2b_press: got %h want %h", obs, exp_vec()); end
        if (in_sel === 1'b1) seen = 1;
      end
      vectors++;
      if (seen == 0 || in_data !== {16'h0000, vals[k]}) begin
        miscompares++; $display("FAIL b2b_data: seen %0d in_data %h want 1 %h", seen, in_data, {16'h0000, vals[k]});
      end
      if (k == 1) opcode = 6'd0;
      @(negedge clk); vectors++;
      if (in_sel !== 1'b0) begin miscompares++; $display("FAIL b2b_single_cycle: in_sel %b want 0", in_sel); end
    end
    btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task test_random;
    int hold;
    hold = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL random_cycle %0d: got %h want %h", c, obs, exp_vec()); end
      if (hold == 0) begin btn = ~btn; hold = $urandom_range(1, 12); end
      else hold--;
      case ($urandom_range(0, 7))
        0, 1:    opcode = SYS_IN;
        2:       opcode = SYS_OUT;
        default: opcode = 6'($urandom);
      endcase
      sw_in = 16'($urandom);
      reg_value = $urandom;
      if ($urandom_range(0, 399) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset;
    test_sys_in;
    test_held_button;
    test_glitch;
    test_reset_mid;
    test_sys_out;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
